// File: rtl/decoder_lut.sv
// Registered N-to-2^N active-low decoder with a serially reloadable truth table.
// Optional saturating hit counter is built only when DECODER_LUT_HITCNT_EN is defined.
module decoder_lut #(
   parameter int N = 3,
   parameter logic [(1<<N)-1:0] INIT = 8'hD8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                E1_n,
   input  logic                E2_n,
   input  logic                E3,
   input  logic                in_valid,
   input  logic [N-1:0]        in_sel,
   output logic                out_valid,
   output logic [(1<<N)-1:0]   y_n,
   output logic                L,
   output logic                out_en,
   input  logic                cfg_start,
   input  logic                cfg_valid,
   input  logic                cfg_bit,
   output logic                cfg_busy,
   output logic                cfg_done,
   output logic [15:0]         hit_cnt
);

   localparam int W = 1 << N;
   localparam logic [N:0] LAST_IDX = (N+1)'(W - 1);

   typedef enum logic {IDLE, LOAD} cfg_state_t;

   cfg_state_t        state, state_next;
   logic [N:0]        idx, idx_next;
   logic [W-1:0]      shadow, shadow_next;
   logic [W-1:0]      table_q;
   logic              commit;
   logic              en;

   assign en       = E3 & ~E2_n & ~E1_n;
   assign cfg_busy = (state == LOAD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         shadow   <= '0;
         table_q  <= INIT;
         cfg_done <= 1'b0;
      end else begin
         state    <= state_next;
         idx      <= idx_next;
         shadow   <= shadow_next;
         cfg_done <= commit;
         if (commit) begin
            table_q <= shadow_next;
         end
      end
   end

   // A restart wins over a beat in the same cycle; the final beat is folded into the commit.
   always_comb begin
      state_next  = state;
      idx_next    = idx;
      shadow_next = shadow;
      commit      = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_start) begin
               state_next  = LOAD;
               idx_next    = '0;
               shadow_next = '0;
            end
         end
         LOAD: begin
            if (cfg_start) begin
               idx_next    = '0;
               shadow_next = '0;
            end else if (cfg_valid) begin
               shadow_next[idx[N-1:0]] = cfg_bit;
               idx_next                = idx + 1'b1;
               if (idx == LAST_IDX) begin
                  commit     = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         y_n       <= '1;
         L         <= 1'b0;
         out_en    <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            if (en) begin
               y_n    <= ~(W'(1) << in_sel);
               L      <= table_q[in_sel];
               out_en <= 1'b1;
            end else begin
               y_n    <= '1;
               L      <= 1'b0;
               out_en <= 1'b0;
            end
         end
      end
   end

`ifdef DECODER_LUT_HITCNT_EN
   // Counts registered results, so it trails the visible L=1 output by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt <= 16'h0;
      end else if (out_valid && out_en && L && (hit_cnt != 16'hFFFF)) begin
         hit_cnt <= hit_cnt + 16'h1;
      end
   end
`else
   assign hit_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_decoder_lut.sv
// Scoreboard bench for decoder_lut (N=3): stimulus pushes expected results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_decoder_lut;

   typedef struct {
      logic [7:0] y;
      logic       l;
      logic       en;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        E1_n, E2_n, E3;
   logic        in_valid;
   logic [2:0]  in_sel;
   logic        out_valid;
   logic [7:0]  y_n;
   logic        L;
   logic        out_en;
   logic        cfg_start, cfg_valid, cfg_bit;
   logic        cfg_busy, cfg_done;
   logic [15:0] hit_cnt;

   exp_t        sb[$];
   logic [7:0]  tb_table;
   int          checks = 0;
   int          errors = 0;

   decoder_lut #(.N(3), .INIT(8'hD8)) dut (
      .clk(clk), .rst(rst), .E1_n(E1_n), .E2_n(E2_n), .E3(E3),
      .in_valid(in_valid), .in_sel(in_sel), .out_valid(out_valid),
      .y_n(y_n), .L(L), .out_en(out_en), .cfg_start(cfg_start),
      .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_busy(cfg_busy),
      .cfg_done(cfg_done), .hit_cnt(hit_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, record the expected result, then step past the edge.
   task automatic applyStimulus(input logic valid, input logic [2:0] sel,
                                input logic e1n, input logic e2n, input logic e3,
                                input logic start, input logic cv, input logic cb);
      exp_t e;
      in_valid  = valid;
      in_sel    = sel;
      E1_n      = e1n;
      E2_n      = e2n;
      E3        = e3;
      cfg_start = start;
      cfg_valid = cv;
      cfg_bit   = cb;
      if (valid) begin
         e.en = e3 & ~e2n & ~e1n;
         e.y  = e.en ? ~(8'b1 << sel) : 8'hFF;
         e.l  = e.en ? tb_table[sel] : 1'b0;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      idle();
      rst = 1'b0;
      tb_table = 8'hD8;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("y_n", {24'h0, y_n}, {24'h0, e.y});
            checkOutput("L", {31'h0, L}, {31'h0, e.l});
            checkOutput("out_en", {31'h0, out_en}, {31'h0, e.en});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] bits;
      int         dones;
      tb_table = 8'hD8;
      rst = 1'b1;
      in_valid = 1'b0; in_sel = 3'd0; E1_n = 1'b0; E2_n = 1'b0; E3 = 1'b1;
      cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] reset defaults");
      checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
      checkOutput("rst_y_n", {24'h0, y_n}, 32'hFF);
      checkOutput("rst_L", {31'h0, L}, 32'h0);
      checkOutput("rst_out_en", {31'h0, out_en}, 32'h0);
      checkOutput("rst_cfg_busy", {31'h0, cfg_busy}, 32'h0);
      checkOutput("rst_cfg_done", {31'h0, cfg_done}, 32'h0);
      checkOutput("rst_hit_cnt", {16'h0, hit_cnt}, 32'h0);

      for (int s = 0; s < 8; s++)
         applyStimulus(1'b1, 3'(s), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("hold_out_valid", {31'h0, out_valid}, 32'h0);
      checkOutput("hold_y_n", {24'h0, y_n}, 32'h7F);
      checkOutput("hold_L", {31'h0, L}, 32'h1);

      $display("[TB] disable");
      applyStimulus(1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();

      $display("[TB] reload 8'h81");
      bits = 8'h81;
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("load_busy", {31'h0, cfg_busy}, 32'h1);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, bits[i]);
         if (i < 7) begin
            checkOutput("load_busy_beat", {31'h0, cfg_busy}, 32'h1);
            checkOutput("load_done_early", {31'h0, cfg_done}, 32'h0);
         end
      end
      tb_table = 8'h81;
      checkOutput("commit_busy", {31'h0, cfg_busy}, 32'h0);
      checkOutput("commit_done", {31'h0, cfg_done}, 32'h1);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("done_pulse_end", {31'h0, cfg_done}, 32'h0);
      applyStimulus(1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();

      $display("[TB] abort and restart");
      dones = 0;
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
         checkOutput("abort_busy", {31'h0, cfg_busy}, 32'h1);
      end
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("restart_busy", {31'h0, cfg_busy}, 32'h1);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
         if (cfg_done) dones++;
         if (i < 7) checkOutput("restart_busy_beat", {31'h0, cfg_busy}, 32'h1);
      end
      tb_table = 8'hFF;
      idle();
      if (cfg_done) dones++;
      checkOutput("restart_done_count", dones, 32'd1);
      applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();

      $display("[TB] reset mid-load");
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      doReset();
      checkOutput("midrst_busy", {31'h0, cfg_busy}, 32'h0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
         if (cfg_done || cfg_busy) dones++;
      end
      idle();
      if (cfg_done) dones++;
      checkOutput("idle_beats_ignored", dones, 32'd0);
      applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();

      $display("[TB] hit counter");
      doReset();
      checkOutput("hit_cnt_reset", {16'h0, hit_cnt}, 32'h0);
      for (int i = 0; i < 10; i++) begin
         case (i % 4)
            0: applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            1: applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            2: applyStimulus(1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            default: applyStimulus(1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         endcase
         if (i < 5) applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      repeat (3) idle();
`ifdef DECODER_LUT_HITCNT_EN
      checkOutput("hit_cnt", {16'h0, hit_cnt}, 32'd10);
`else
      checkOutput("hit_cnt", {16'h0, hit_cnt}, 32'd0);
`endif

      checkOutput("scoreboard_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder_lut.md
# decoder_lut

Parametrised, registered N-to-2^N decoder with a runtime-programmable truth table. It generalises the fixed 3-8 decoder plus minterm-OR structure. Each accepted select value produces an active-low one-hot decode and a single-bit logic function L = TABLE[select], both registered. The truth table loads serially through a small configuration state machine, commits atomically, and can be reprogrammed while evaluation continues.

## Interface
- N, default 3: select width; legal range 1..6; decode width W = 2^N.
- INIT, default 8'hD8 (W bits): reset truth table; bit k = L for select k. The default sets minterms 3,4,6,7.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- E1_n  input  1  enable, active-low.
- E2_n  input  1  enable, active-low.
- E3  input  1  enable, active-high.
- in_valid  input  1  evaluate request this cycle.
- in_sel  input  N  select; bit 0 is the LSB (the old A0).
- out_valid  output  1  y_n, L and out_en valid; a one-cycle pulse per request.
- y_n  output  W  registered active-low one-hot decode.
- L  output  1  registered function value.
- out_en  output  1  registered enable state of the request.
- cfg_start  input  1  pulse; begin or restart a table load.
- cfg_valid  input  1  one table bit presented on cfg_bit.
- cfg_bit  input  1  table bit; beats are in index order 0..W-1.
- cfg_busy  output  1  high while a load is in progress.
- cfg_done  output  1  one-cycle pulse in the cycle after commit.
- hit_cnt  output  16  count of L=1 results (see Configuration).

## Operation
- Enable: en = E3 & ~E2_n & ~E1_n, sampled with in_valid.
- Evaluate: each in_valid cycle registers one result. No backpressure: a request is accepted every cycle.
  - If en=1: y_n[in_sel]=0, all other bits of y_n = 1, L = TABLE[in_sel], out_en = 1.
  - If en=0: y_n = all ones, L = 0, out_en = 0, out_valid = 1.
- When in_valid=0: out_valid=0; y_n, L and out_en hold their last values.
- Config FSM has two states, IDLE and LOAD.
  - IDLE to LOAD on cfg_start. This clears idx and sets cfg_busy.
  - In LOAD, each cfg_valid writes cfg_bit into SHADOW[idx], then idx increments. idx is N+1 bits wide.
  - When the beat at idx = W-1 is accepted, TABLE <= SHADOW including that final bit, the FSM returns to IDLE, and cfg_done pulses next cycle.
  - cfg_start in LOAD restarts: idx = 0 and the partial shadow is discarded. If cfg_start and cfg_valid occur together, cfg_start wins and the bit is dropped.
  - cfg_valid in IDLE is ignored.
  - TABLE changes only at commit, never bit by bit.
- Evaluate during LOAD uses the old TABLE.
- A request in the commit cycle uses the old TABLE; requests from the next cycle on use the new one.
- Reset, including mid-load: TABLE=INIT, FSM=IDLE, idx=0, y_n=all ones, L=0, out_en=0, out_valid=0, cfg_busy=0, cfg_done=0, hit_cnt=0. A partial load is lost.

## Timing
- Evaluate latency is 1 cycle: a request at edge t appears on the outputs after edge t, with out_valid high for that one cycle.
- Throughput is 1 request per cycle, back to back.
- A load takes W cfg_valid beats minimum, with gaps allowed between beats.
- The new table is effective for requests sampled at edge c+1, where c is the commit edge; cfg_done is high during that cycle.
- cfg_busy falls at the commit edge.
- Simultaneous rst with any input: reset wins.

## Configuration
- DECODER_LUT_HITCNT_EN defined:
  - hit_cnt is a 16-bit saturating counter, incremented on each registered result with out_valid=1, out_en=1 and L=1.
  - It holds at 16'hFFFF and clears only on rst.
- Not defined: hit_cnt is tied to 16'h0 and no counter logic is built. All other behaviour is identical.

## Test plan
- Reset defaults: after rst, in_valid=1, en=1, sweep in_sel 0..7 one per cycle. Require L sequence 0,0,0,1,1,0,1,1 and y_n = ~(8'b1<<sel) each one cycle later.
- Disable: E2_n=1, in_valid=1, in_sel=5. Require next cycle out_valid=1, y_n=8'hFF, L=0, out_en=0.
- Reload: cfg_start, then 8 beats of bits 1,0,0,0,0,0,0,1 (TABLE=8'h81) with a request at sel=0 every cycle.
  - Require L=0 through and including the commit-cycle request, then L=1.
  - Require cfg_done for one cycle; after it, sel=7 gives L=1 and sel=3 gives L=0.
- Abort/restart: cfg_start, 4 beats, cfg_start again, 8 beats of 1. Require TABLE=8'hFF, a single cfg_done, and cfg_busy high throughout.
- Reset mid-load: cfg_start, 3 beats, rst. Require cfg_busy=0 and TABLE=8'hD8 (sel=3 gives L=1); subsequent cfg_valid pulses are ignored.
- With DECODER_LUT_HITCNT_EN and N=3: 10 requests hitting minterms plus 5 with en=0. Require hit_cnt=10. Without the macro, hit_cnt=0.
